// File: rtl/dxl_status_parser.sv
// Dynamixel protocol 2.0 status-packet parser fed one byte per rx_valid strobe.
// Optional inter-byte timeout is enabled by defining DXL_STATUS_TIMEOUT_EN.
module dxl_status_parser #(
    parameter int unsigned MAX_PARAMS   = 4,
    parameter int unsigned TIMEOUT_CLKS = 4350
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    input  logic [7:0]              expected_id,
    output logic                    pkt_valid,
    output logic [7:0]              pkt_id,
    output logic [7:0]              pkt_error,
    output logic [3:0]              pkt_param_count,
    output logic [8*MAX_PARAMS-1:0] pkt_params,
    output logic                    crc_error,
    output logic                    frame_error,
    output logic                    busy
);

    if (MAX_PARAMS < 1 || MAX_PARAMS > 8) begin : g_bad_max_params
        $error("MAX_PARAMS must be in 1..8");
    end
    if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 1");
    end

    typedef enum logic [3:0] {
        StHdr1, StHdr2, StHdr3, StRsv, StId, StLenL, StLenH,
        StInstr, StErr, StParam, StCrcL, StCrcH
    } state_e;

    function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else       c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Extra 0xFF bytes before FD are hunt noise, so the accumulator restarts from FF FF FD.
    localparam logic [15:0] HdrCrc = crc_upd(crc_upd(crc_upd(16'h0000, 8'hFF), 8'hFF), 8'hFD);

    state_e                  state_q, state_d;
    logic [15:0]             crc_q, crc_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [3:0]              count_q, count_d;
    logic [3:0]              idx_q, idx_d;
    logic [7:0]              id_q, id_d;
    logic [7:0]              err_q, err_d;
    logic [7:0]              crc_lo_q, crc_lo_d;
    logic [8*MAX_PARAMS-1:0] shadow_q, shadow_d;

    logic                    pkt_valid_q, pkt_valid_d;
    logic [7:0]              pkt_id_q, pkt_id_d;
    logic [7:0]              pkt_error_q, pkt_error_d;
    logic [3:0]              pkt_count_q, pkt_count_d;
    logic [8*MAX_PARAMS-1:0] pkt_params_q, pkt_params_d;
    logic                    crc_error_q, crc_error_d;
    logic                    frame_error_q, frame_error_d;

    logic [15:0] crc_next;
    logic [15:0] len_full;

`ifdef DXL_STATUS_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    assign busy     = (state_q != StHdr1);
    assign crc_next = crc_upd(crc_q, rx_byte);
    assign len_full = {rx_byte, len_lo_q};

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        len_lo_d      = len_lo_q;
        count_d       = count_q;
        idx_d         = idx_q;
        id_d          = id_q;
        err_d         = err_q;
        crc_lo_d      = crc_lo_q;
        shadow_d      = shadow_q;
        pkt_valid_d   = 1'b0;
        pkt_id_d      = pkt_id_q;
        pkt_error_d   = pkt_error_q;
        pkt_count_d   = pkt_count_q;
        pkt_params_d  = pkt_params_q;
        crc_error_d   = 1'b0;
        frame_error_d = 1'b0;

        if (rx_valid) begin
            unique case (state_q)
                StHdr1: begin
                    if (rx_byte == 8'hFF) state_d = StHdr2;
                end
                StHdr2: begin
                    state_d = (rx_byte == 8'hFF) ? StHdr3 : StHdr1;
                end
                StHdr3: begin
                    if (rx_byte == 8'hFD) begin
                        state_d = StRsv;
                        crc_d   = HdrCrc;
                    end else if (rx_byte != 8'hFF) begin
                        state_d = StHdr1;
                    end
                end
                StRsv: begin
                    if (rx_byte == 8'h00) begin
                        state_d = StId;
                        crc_d   = crc_next;
                    end else begin
                        state_d       = StHdr1;
                        frame_error_d = 1'b1;
                    end
                end
                StId: begin
                    if (rx_byte == expected_id || rx_byte == 8'hFE) begin
                        state_d  = StLenL;
                        crc_d    = crc_next;
                        id_d     = rx_byte;
                        shadow_d = '0;
                    end else begin
                        state_d = StHdr1;
                    end
                end
                StLenL: begin
                    state_d  = StLenH;
                    crc_d    = crc_next;
                    len_lo_d = rx_byte;
                end
                StLenH: begin
                    if (len_full < 16'd4 || len_full > 16'(MAX_PARAMS + 4)) begin
                        state_d       = StHdr1;
                        frame_error_d = 1'b1;
                    end else begin
                        state_d = StInstr;
                        crc_d   = crc_next;
                        count_d = len_full[3:0] - 4'd4;
                    end
                end
                StInstr: begin
                    if (rx_byte == 8'h55) begin
                        state_d = StErr;
                        crc_d   = crc_next;
                    end else begin
                        state_d       = StHdr1;
                        frame_error_d = 1'b1;
                    end
                end
                StErr: begin
                    crc_d   = crc_next;
                    err_d   = rx_byte;
                    idx_d   = 4'd0;
                    state_d = (count_q != 4'd0) ? StParam : StCrcL;
                end
                StParam: begin
                    crc_d = crc_next;
                    for (int i = 0; i < int'(MAX_PARAMS); i++) begin
                        if (idx_q == 4'(i)) shadow_d[i*8 +: 8] = rx_byte;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q + 4'd1 == count_q) state_d = StCrcL;
                end
                StCrcL: begin
                    crc_lo_d = rx_byte;
                    state_d  = StCrcH;
                end
                StCrcH: begin
                    state_d = StHdr1;
                    if ({rx_byte, crc_lo_q} == crc_q) begin
                        pkt_valid_d  = 1'b1;
                        pkt_id_d     = id_q;
                        pkt_error_d  = err_q;
                        pkt_count_d  = count_q;
                        pkt_params_d = shadow_q;
                    end else begin
                        crc_error_d = 1'b1;
                    end
                end
                default: state_d = StHdr1;
            endcase
        end

`ifdef DXL_STATUS_TIMEOUT_EN
        // Only idle cycles inside a packet count toward the timeout.
        if (!busy || rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q == TmoW'(TIMEOUT_CLKS - 1)) begin
            tmo_d         = '0;
            state_d       = StHdr1;
            frame_error_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StHdr1;
            crc_q         <= '0;
            len_lo_q      <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            id_q          <= '0;
            err_q         <= '0;
            crc_lo_q      <= '0;
            shadow_q      <= '0;
            pkt_valid_q   <= 1'b0;
            pkt_id_q      <= '0;
            pkt_error_q   <= '0;
            pkt_count_q   <= '0;
            pkt_params_q  <= '0;
            crc_error_q   <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef DXL_STATUS_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_lo_q      <= len_lo_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            id_q          <= id_d;
            err_q         <= err_d;
            crc_lo_q      <= crc_lo_d;
            shadow_q      <= shadow_d;
            pkt_valid_q   <= pkt_valid_d;
            pkt_id_q      <= pkt_id_d;
            pkt_error_q   <= pkt_error_d;
            pkt_count_q   <= pkt_count_d;
            pkt_params_q  <= pkt_params_d;
            crc_error_q   <= crc_error_d;
            frame_error_q <= frame_error_d;
`ifdef DXL_STATUS_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    assign pkt_valid       = pkt_valid_q;
    assign pkt_id          = pkt_id_q;
    assign pkt_error       = pkt_error_q;
    assign pkt_param_count = pkt_count_q;
    assign pkt_params      = pkt_params_q;
    assign crc_error       = crc_error_q;
    assign frame_error     = frame_error_q;

endmodule

// File: tb/tb_dxl_status_parser.sv
// Directed bench for dxl_status_parser; also covers the DXL_STATUS_TIMEOUT_EN build.
module tb_dxl_status_parser;

    localparam int unsigned MaxParams = 4;
    localparam int unsigned Tmo       = 4350;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   rx_valid = 1'b0;
    logic [7:0]             rx_byte = 8'h00;
    logic [7:0]             expected_id = 8'h01;
    logic                   pkt_valid;
    logic [7:0]             pkt_id;
    logic [7:0]             pkt_error;
    logic [3:0]             pkt_param_count;
    logic [8*MaxParams-1:0] pkt_params;
    logic                   crc_error;
    logic                   frame_error;
    logic                   busy;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_crc = 0;
    int n_frame = 0;
    int v0, c0, f0;
    int seen;
    logic [7:0] pkt[$];

    dxl_status_parser #(
        .MAX_PARAMS  (MaxParams),
        .TIMEOUT_CLKS(Tmo)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .expected_id    (expected_id),
        .pkt_valid      (pkt_valid),
        .pkt_id         (pkt_id),
        .pkt_error      (pkt_error),
        .pkt_param_count(pkt_param_count),
        .pkt_params     (pkt_params),
        .crc_error      (crc_error),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (pkt_valid)   n_valid <= n_valid + 1;
        if (crc_error)   n_crc   <= n_crc + 1;
        if (frame_error) n_frame <= n_frame + 1;
        if (pkt_valid || crc_error || frame_error)
            check("pulse_onehot", 64'($countones({pkt_valid, crc_error, frame_error})), 64'd1);
    end

    // Bit-serial CRC-16/0x8005 over the whole queued packet.
    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (pkt[i]) begin
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ pkt[i][j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic add_crc();
        logic [15:0] c;
        c = crc_model();
        pkt.push_back(c[7:0]);
        pkt.push_back(c[15:8]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic snap();
        v0 = n_valid;
        c0 = n_crc;
        f0 = n_frame;
    endtask

    initial begin
        reset = 1'b1;
        tick(3);
        check("rst_valid", pkt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_id", pkt_id, 0);
        check("rst_params", pkt_params, 0);
        check("rst_pulses", {crc_error, frame_error, pkt_param_count, pkt_error}, 0);
        reset = 1'b0;
        tick(2);

        // Reference status packet
        snap();
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55,
                8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        send_pkt();
        check("good_valid", pkt_valid, 1);
        check("good_id", pkt_id, 8'h01);
        check("good_err", pkt_error, 8'h00);
        check("good_count", pkt_param_count, 3);
        check("good_params", pkt_params, 32'h0026_0406);
        check("good_busy", busy, 0);
        tick(1);
        check("good_pulse_width", pkt_valid, 0);
        check("good_npulse", n_valid - v0, 1);

        // Corrupted CRC high byte
        snap();
        pkt[13] = 8'h5C;
        send_pkt();
        check("crc_err_pulse", crc_error, 1);
        check("crc_err_novalid", pkt_valid, 0);
        check("crc_err_hold_id", pkt_id, 8'h01);
        check("crc_err_hold_params", pkt_params, 32'h0026_0406);
        tick(1);
        check("crc_err_counts", {n_crc - c0, n_valid - v0}, {32'd1, 32'd0});

        // Zero-parameter packet after a CRC error
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h04, 8'h00, 8'h55, 8'h05};
        add_crc();
        send_pkt();
        check("zp_valid", pkt_valid, 1);
        check("zp_err", pkt_error, 8'h05);
        check("zp_count", pkt_param_count, 0);
        check("zp_params", pkt_params, 0);

        // Extra 0xFF in the header
        pkt = '{8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55,
                8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        send_pkt();
        check("ff3_valid", pkt_valid, 1);
        check("ff3_params", pkt_params, 32'h0026_0406);

        // Foreign ID is dropped silently
        tick(1);
        snap();
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h02};
        send_pkt();
        check("wrong_id_busy", busy, 0);
        pkt = '{8'h07, 8'h00, 8'h55, 8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        send_pkt();
        tick(1);
        check("wrong_id_nopulse", (n_valid - v0) + (n_crc - c0) + (n_frame - f0), 0);
        check("wrong_id_hold", pkt_params, 32'h0026_0406);

        // Broadcast ID
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'hFE, 8'h05, 8'h00, 8'h55, 8'h00, 8'hAB};
        add_crc();
        send_pkt();
        check("bcast_valid", pkt_valid, 1);
        check("bcast_id", pkt_id, 8'hFE);
        check("bcast_count_params", {pkt_param_count, pkt_params}, {4'd1, 32'h0000_00AB});

        // Header hunt noise raises nothing
        tick(1);
        snap();
        pkt = '{8'hFF, 8'h12, 8'hFF, 8'hFF, 8'h34};
        send_pkt();
        tick(1);
        check("hunt_nopulse", (n_valid - v0) + (n_crc - c0) + (n_frame - f0), 0);
        check("hunt_busy", busy, 0);

        // Length and format violations
        snap();
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h0A, 8'h00};
        send_pkt();
        check("len_big_ferr", frame_error, 1);
        check("len_big_busy", busy, 0);
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h03, 8'h00};
        send_pkt();
        check("len_small_ferr", frame_error, 1);
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h03};
        send_pkt();
        check("instr_ferr", frame_error, 1);
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h01};
        send_pkt();
        check("rsv_ferr", frame_error, 1);
        tick(1);
        check("ferr_count", n_frame - f0, 4);

        // Exactly MAX_PARAMS parameters
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h08, 8'h00, 8'h55, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44};
        add_crc();
        send_pkt();
        check("max_valid", pkt_valid, 1);
        check("max_count", pkt_param_count, 4);
        check("max_params", pkt_params, 32'h4433_2211);

        // Stall after six bytes
        tick(1);
        snap();
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07};
        send_pkt();
`ifdef DXL_STATUS_TIMEOUT_EN
        seen = 0;
        for (int k = 0; k < int'(Tmo) + 20 && seen == 0; k++) begin
            @(negedge clock);
            if (frame_error) seen = k + 1;
        end
        check("tmo_latency", seen, Tmo);
        check("tmo_busy", busy, 0);
`else
        tick(Tmo + 100);
        check("notmo_busy", busy, 1);
        check("notmo_noferr", n_frame - f0, 0);
        pkt = '{8'h00, 8'h55, 8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        send_pkt();
        check("notmo_resume_valid", pkt_valid, 1);
`endif

        // Reset in the middle of a packet
        tick(1);
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55};
        send_pkt();
        snap();
        reset = 1'b1;
        tick(3);
        check("midrst_busy", busy, 0);
        check("midrst_outputs", {pkt_id, pkt_params, pkt_param_count}, 0);
        reset = 1'b0;
        tick(2);
        check("midrst_nopulse", (n_valid - v0) + (n_crc - c0) + (n_frame - f0), 0);
        pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55,
                8'h00, 8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};
        send_pkt();
        tick(2);
        check("midrst_one_valid", n_valid - v0, 1);
        check("midrst_no_err", (n_crc - c0) + (n_frame - f0), 0);
        check("midrst_params", pkt_params, 32'h0026_0406);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dxl_status_parser.md
DXL_STATUS_PARSER -- requirements
Module: dxl_status_parser

Interface
REQ-001 SHALL have parameter MAX_PARAMS, default 4: maximum status parameter bytes accepted (1..8).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 4350: inter-byte timeout in clocks (10 bit times at CLKS_PER_BIT 435).
REQ-003 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_valid  in  1  one-cycle strobe; rx_byte is valid on this cycle (uart_rx o_Rx_DV).
REQ-006 SHALL have port rx_byte  in  8  received byte.
REQ-007 SHALL have port expected_id  in  8  servo ID to accept; sampled when the ID byte arrives.
REQ-008 SHALL have port pkt_valid  out  1  one-cycle pulse: good status packet committed.
REQ-009 SHALL have port pkt_id  out  8  ID of last good packet.
REQ-010 SHALL have port pkt_error  out  8  error byte of last good packet.
REQ-011 SHALL have port pkt_param_count  out  4  parameter byte count of last good packet.
REQ-012 SHALL have port pkt_params  out  8*MAX_PARAMS  parameters, first byte in [7:0]; unused bytes zero.
REQ-013 SHALL have port crc_error  out  1  one-cycle pulse: CRC mismatch.
REQ-014 SHALL have port frame_error  out  1  one-cycle pulse: format, length or timeout violation.
REQ-015 SHALL have port busy  out  1  high whenever state is not HDR1.

Function
REQ-016 SHALL be a state machine: HDR1, HDR2, HDR3, RSV, ID, LEN_L, LEN_H, INSTR, ERR, PARAM, CRC_L, CRC_H; transitions advance only on rx_valid.
REQ-017 Header hunt SHALL be: HDR1 needs 0xFF; HDR2 needs 0xFF, else HDR1; HDR3 needs 0xFD, stays in HDR3 on 0xFF, else HDR1. No error pulses are raised during the hunt.
REQ-018 RSV byte SHALL be 0x00; any other value SHALL pulse frame_error and return to HDR1.
REQ-019 ID byte SHALL equal expected_id or 0xFE; on mismatch the block SHALL return silently to HDR1 with no pulse.
REQ-020 LEN = {LEN_H, LEN_L}; the parameter count SHALL be LEN-4; LEN<4 or LEN-4>MAX_PARAMS SHALL pulse frame_error after LEN_H and return to HDR1.
REQ-021 INSTR byte SHALL be 0x55, else frame_error and HDR1.
REQ-022 After ERR, the block SHALL go to PARAM if the count is >0, else to CRC_L; PARAM SHALL exit to CRC_L after exactly count bytes.
REQ-023 CRC SHALL be CRC-16, polynomial 0x8005, init 0x0000, unreflected, no final XOR, over every byte from the first 0xFF through the last parameter, updated one byte per rx_valid.
REQ-024 The received CRC SHALL be low byte first; comparison SHALL occur on the CRC_H byte.
REQ-025 On a CRC match, pkt_valid and the pkt_* registers SHALL update on the clock edge after the CRC_H rx_valid cycle (latency 1); the state SHALL go to HDR1.
REQ-026 On a CRC mismatch, crc_error SHALL pulse at the same latency and the pkt_* outputs SHALL remain unchanged.
REQ-027 Parameters SHALL be collected in a shadow buffer; pkt_* outputs SHALL change only on commit and SHALL hold until the next commit.
REQ-028 Byte stuffing (FF FF FD FD) SHALL NOT be removed; stuffed packets SHALL fail the length or CRC check.
REQ-029 At most one of pkt_valid, crc_error and frame_error SHALL be high in any cycle.

Reset
REQ-030 Reset SHALL force state HDR1, clear the CRC accumulator and shadow buffer, and set all outputs to 0.
REQ-031 Reset mid-packet SHALL discard the partial packet with no pulse; after release the block SHALL hunt for a fresh header.

Configuration
REQ-032 Macro DXL_STATUS_TIMEOUT_EN defined: a counter SHALL clear on each rx_valid while busy and increment otherwise; reaching TIMEOUT_CLKS while busy SHALL pulse frame_error and force HDR1.
REQ-033 Macro DXL_STATUS_TIMEOUT_EN undefined: no counter SHALL exist; the block SHALL wait indefinitely between bytes, and TIMEOUT_CLKS SHALL be unused.

Verification
REQ-034 Send FF FF FD 00 01 07 00 55 00 06 04 26 65 5D with expected_id=01 -> one pkt_valid; pkt_id=01, pkt_error=00, count=3, pkt_params=0x00260406.
REQ-035 Send the same packet with the last byte 5C -> crc_error pulse; pkt_* unchanged; the next good packet is accepted.
REQ-036 Send FF FF FF FD 00 01 07 00 55 00 06 04 26 65 5D -> pkt_valid (HDR3 0xFF hold); send the packet with ID 02 while expected_id=01 -> no pulse, busy low after the ID byte.
REQ-037 Send LEN=0x000A with MAX_PARAMS=4 -> frame_error one cycle after LEN_H; INSTR byte 0x03 -> frame_error.
REQ-038 With DXL_STATUS_TIMEOUT_EN, stop after 6 bytes -> frame_error exactly TIMEOUT_CLKS clocks after the last rx_valid; without the macro, no pulse and the packet completes when resumed.
REQ-039 Assert reset after the 8th byte, then send a full good packet -> no pulse during reset; exactly one pkt_valid afterwards.
